// File: rtl/la_select_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// la_select_pkg
// Shared definitions for the LA select sequencer: register offsets, register
// bit positions, the LA bus width and the switch-sequencing FSM encoding.
// Ports: none (package).
// ----------------------------------------------------------------------------
package la_select_pkg;

    localparam int LA_WIDTH = 128;

    // Word offsets within the 16-byte register window (adr[3:2])
    localparam logic [1:0] REG_SEL    = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // CTRL fields
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLANK_LSB = 8;

    // STATUS fields
    localparam int STATUS_BUSY_BIT   = 0;
    localparam int STATUS_ACTIVE_LSB = 8;
    localparam int STATUS_ERR_BIT    = 16;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_BLANK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/la_select_sequencer_if.sv
// ----------------------------------------------------------------------------
// la_select_sequencer_if
// Wishbone slave bus bundle for the LA select sequencer.
// Signals: wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0],
//          wbs_dat_i[31:0] (master -> slave); wbs_ack_o, wbs_dat_o[31:0]
//          (slave -> master).
// Modports: master (bus initiator / testbench), slave (the sequencer).
// ----------------------------------------------------------------------------
interface la_select_sequencer_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/la_select_sequencer_mux.sv
// ----------------------------------------------------------------------------
// la_select_mux
// Combinational N:1 selector over the packed team LA buses. Team t occupies
// data_i[128*t-1 -: 128]; index 0 or any index above NUM_TEAMS yields zero.
// Ports:
//   idx_i   in  8                    selected team (1..NUM_TEAMS, 0 = none)
//   data_i  in  LA_WIDTH*NUM_TEAMS   packed team LA data
//   data_o  out LA_WIDTH             selected word (unregistered)
// ----------------------------------------------------------------------------
module la_select_mux
    import la_select_pkg::*;
#(
    parameter int NUM_TEAMS = 1
) (
    input  logic [7:0]                   idx_i,
    input  logic [LA_WIDTH*NUM_TEAMS-1:0] data_i,
    output logic [LA_WIDTH-1:0]          data_o
);

    // Only an exact match on a legal team index passes data; everything else
    // falls through to the zero default.
    always_comb begin
        data_o = '0;
        for (int t = 1; t <= NUM_TEAMS; t++) begin
            if (idx_i == 8'(t)) begin
                data_o = data_i[t*LA_WIDTH-1 -: LA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/la_select_sequencer.sv
// ----------------------------------------------------------------------------
// la_select_sequencer
// Wishbone-programmable controller choosing which team's 128-bit LA bus drives
// la_data_out. Every source change is sequenced: blank the output, wait a
// programmable gap, commit the new source, then resume, so no stale or mixed
// words reach the LA pins.
// Ports:
//   clk                  in  1                  system / Wishbone clock
//   nrst                 in  1                  async active-low reset
//   wb                   slave modport          Wishbone register access
//   designs_la_data_out  in  128*NUM_TEAMS      packed team LA data
//   la_data_out          out 128                registered selected LA data
//   busy                 out 1                  switch sequence in progress
// ----------------------------------------------------------------------------
module la_select_sequencer
    import la_select_pkg::*;
#(
    parameter int          NUM_TEAMS = 1,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [7:0]  BLANK_RST = 8'd4
) (
    input  logic                          clk,
    input  logic                          nrst,
    la_select_sequencer_if.slave          wb,
    input  logic [LA_WIDTH*NUM_TEAMS-1:0] designs_la_data_out,
    output logic [LA_WIDTH-1:0]           la_data_out,
    output logic                          busy
);

    localparam logic [7:0] MAX_TEAM = 8'(NUM_TEAMS);

    logic                ack_q;
    logic [31:0]         datOut_q;
    logic [7:0]          pending_q;
    logic                enable_q;
    logic [7:0]          blankCycles_q;
    logic                err_q;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          active_q, active_d;
    logic [LA_WIDTH-1:0] laData_q, laData_d;

    logic                hit;
    logic                access;
    logic                wrEn;
    logic [1:0]          regIdx;
    logic [7:0]          selVal;
    logic                selWr;
    logic                selValid;
    logic                reqAccept;
    logic                errSet;
    logic                errClr;
    logic [31:0]         rdData;
    logic [LA_WIDTH-1:0] muxData;
    logic [8:0]          cntNext;
    logic                lastBlank;
    logic                unusedBits;

    // Bus decode. A new access is only taken while ack is low, which gives the
    // single-cycle ack and keeps a held strobe from being acked back to back.
    always_comb begin
        hit       = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
        access    = hit & ~ack_q;
        wrEn      = access & wb.wbs_we_i;
        regIdx    = wb.wbs_adr_i[3:2];
        selVal    = wb.wbs_dat_i[7:0];
        selWr     = wrEn && (regIdx == REG_SEL) && wb.wbs_sel_i[0];
        selValid  = (selVal <= MAX_TEAM);
        // Re-requesting the team already pending is a no-op only when idle;
        // during BLANK/COMMIT any valid request restarts the gap.
        reqAccept = selWr && selValid && !((state_q == ST_ACTIVE) && (selVal == pending_q));
        errSet    = selWr && !selValid;
        errClr    = wrEn && (regIdx == REG_STATUS) && wb.wbs_sel_i[2] && wb.wbs_dat_i[STATUS_ERR_BIT];
    end

    // Register read mux
    always_comb begin
        rdData = '0;
        case (regIdx)
            REG_SEL: begin
                rdData[7:0] = pending_q;
            end
            REG_CTRL: begin
                rdData[CTRL_EN_BIT]                 = enable_q;
                rdData[CTRL_BLANK_LSB +: 8]         = blankCycles_q;
            end
            REG_STATUS: begin
                rdData[STATUS_BUSY_BIT]             = busy;
                rdData[STATUS_ACTIVE_LSB +: 8]      = active_q;
                rdData[STATUS_ERR_BIT]              = err_q;
            end
            default: begin
                rdData = '0;
            end
        endcase
    end

    // Wishbone slave and programmable registers. Writes land on the same edge
    // that raises ack, so the new value is visible during the ack cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack_q         <= 1'b0;
            datOut_q      <= '0;
            pending_q     <= '0;
            enable_q      <= 1'b0;
            blankCycles_q <= BLANK_RST;
            err_q         <= 1'b0;
        end else begin
            ack_q    <= access;
            datOut_q <= (access && !wb.wbs_we_i) ? rdData : '0;
            if (reqAccept) begin
                pending_q <= selVal;
            end
            if (wrEn && (regIdx == REG_CTRL)) begin
                if (wb.wbs_sel_i[0]) begin
                    enable_q <= wb.wbs_dat_i[CTRL_EN_BIT];
                end
                if (wb.wbs_sel_i[1]) begin
                    blankCycles_q <= wb.wbs_dat_i[CTRL_BLANK_LSB +: 8];
                end
            end
            if (errSet) begin
                err_q <= 1'b1;
            end else if (errClr) begin
                err_q <= 1'b0;
            end
        end
    end

    la_select_mux #(
        .NUM_TEAMS (NUM_TEAMS)
    ) u_mux (
        .idx_i  (active_q),
        .data_i (designs_la_data_out),
        .data_o (muxData)
    );

    // Switch sequencer next-state logic. BLANK lasts max(blank_cycles, 1)
    // cycles: the exit test looks at the count the next cycle would reach.
    // The counter only advances while below the compare value, so it cannot
    // wrap even if blank_cycles is lowered mid-sequence. COMMIT always
    // completes its active update; a request arriving then just re-enters
    // BLANK with the newer pending value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        laData_d  = '0;
        busy      = (state_q != ST_ACTIVE);
        cntNext   = {1'b0, cnt_q} + 9'd1;
        lastBlank = (blankCycles_q == 8'd0) || (cntNext >= {1'b0, blankCycles_q});
        case (state_q)
            ST_ACTIVE: begin
                if (enable_q && (active_q != 8'd0)) begin
                    laData_d = muxData;
                end
            end
            ST_BLANK: begin
                if (lastBlank) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_COMMIT: begin
                active_d = pending_q;
                state_d  = ST_ACTIVE;
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
        if (reqAccept) begin
            state_d = ST_BLANK;
            cnt_d   = 8'd0;
        end
    end

    // Sequencer state and the LA output register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_ACTIVE;
            cnt_q    <= '0;
            active_q <= '0;
            laData_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            laData_q <= laData_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = datOut_q;
    assign la_data_out  = laData_q;

    // Address and data bits outside the decoded fields
    assign unusedBits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:17], wb.wbs_sel_i[3]};

endmodule

// File: tb/tb_la_select_sequencer.sv
// ----------------------------------------------------------------------------
// tb_la_select_sequencer
// Self-checking bench for la_select_sequencer with three teams. Register reads
// and LA output words are predicted by the bench and queued; they are popped
// and compared when the DUT acks or the output register updates.
// ----------------------------------------------------------------------------
module tb_la_select_sequencer;

    localparam int          NUM_TEAMS = 3;
    localparam logic [31:0] BASE      = 32'h3000_0000;
    localparam logic [31:0] A_SEL     = BASE + 32'h0;
    localparam logic [31:0] A_CTRL    = BASE + 32'h4;
    localparam logic [31:0] A_STATUS  = BASE + 32'h8;

    logic                      clk = 1'b0;
    logic                      nrst;
    logic [127:0]              teamData [1:NUM_TEAMS];
    logic [128*NUM_TEAMS-1:0]  designsLa;
    logic [127:0]              laOut;
    logic                      busyOut;

    int                        assertCount = 0;
    int                        failCount   = 0;
    logic [31:0]               rdQ [$];
    logic [127:0]              laQ [$];
    int                        modelActive = 0;
    logic                      modelEnable = 1'b0;
    logic                      watchTeam2  = 1'b0;
    logic                      sawTeam2    = 1'b0;
    int                        n;

    la_select_sequencer_if wbIf ();

    assign designsLa = {teamData[3], teamData[2], teamData[1]};

    la_select_sequencer #(
        .NUM_TEAMS (NUM_TEAMS),
        .BASE_ADDR (BASE),
        .BLANK_RST (8'd4)
    ) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .wb                  (wbIf.slave),
        .designs_la_data_out (designsLa),
        .la_data_out         (laOut),
        .busy                (busyOut)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Flags any cycle in which team 2's word shows up on the LA while watched
    always @(negedge clk) begin
        if (watchTeam2 && (laOut == teamData[2])) begin
            sawTeam2 = 1'b1;
        end
    end

    // Hard stop in case something below stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One Wishbone transaction, started at a negedge. Returns at the negedge on
    // which ack was seen (or after the timeout) with the strobe released.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                                 input logic [31:0] dat, input logic [3:0] sel, input logic expectAck);
        logic acked;
        acked = 1'b0;
        wbIf.wbs_cyc_i = 1'b1;
        wbIf.wbs_stb_i = 1'b1;
        wbIf.wbs_we_i  = we;
        wbIf.wbs_adr_i = adr;
        wbIf.wbs_dat_i = dat;
        wbIf.wbs_sel_i = sel;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (wbIf.wbs_ack_o) begin
                acked = 1'b1;
            end
        end
        if (acked && !we && rdQ.size() > 0) begin
            checkOutput({tag, " rdata"}, 128'(wbIf.wbs_dat_o), 128'(rdQ.pop_front()));
        end else if (!acked && !we && rdQ.size() > 0) begin
            void'(rdQ.pop_front());
        end
        wbIf.wbs_cyc_i = 1'b0;
        wbIf.wbs_stb_i = 1'b0;
        wbIf.wbs_we_i  = 1'b0;
        checkOutput({tag, " ack"}, 128'(acked), 128'(expectAck));
    endtask

    task automatic readReg(input string tag, input logic [31:0] adr, input logic [31:0] expected);
        rdQ.push_back(expected);
        applyStimulus(tag, 1'b0, adr, 32'h0, 4'hf, 1'b1);
    endtask

    task automatic writeReg(input string tag, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        applyStimulus(tag, 1'b1, adr, dat, sel, 1'b1);
    endtask

    // Counts consecutive negedges with busy high, starting at the current one
    task automatic countBusy(output int cycles);
        cycles = 0;
        while (busyOut && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    function automatic logic [127:0] modelLa();
        if (modelEnable && modelActive != 0) begin
            return teamData[modelActive];
        end
        return '0;
    endfunction

    // Predict the word the output flop captures on the next edge, then check it
    task automatic checkLaNext(input string tag);
        laQ.push_back(modelLa());
        @(negedge clk);
        checkOutput(tag, laOut, laQ.pop_front());
    endtask

    task automatic driveTeam(input string tag, input int t, input logic [127:0] value);
        teamData[t] = value;
        checkLaNext(tag);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        for (int t = 1; t <= NUM_TEAMS; t++) begin
            teamData[t] = rand128();
        end
        wbIf.wbs_cyc_i = 1'b0;
        wbIf.wbs_stb_i = 1'b0;
        wbIf.wbs_we_i  = 1'b0;
        wbIf.wbs_sel_i = 4'h0;
        wbIf.wbs_adr_i = 32'h0;
        wbIf.wbs_dat_i = 32'h0;
        nrst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst la", laOut, 128'h0);
        checkOutput("rst busy", 128'(busyOut), 128'h0);
        checkOutput("rst ack", 128'(wbIf.wbs_ack_o), 128'h0);
        checkOutput("rst dat_o", 128'(wbIf.wbs_dat_o), 128'h0);
        nrst = 1'b1;
        @(negedge clk);
        readReg("rst status", A_STATUS, 32'h0000_0000);
        readReg("rst ctrl", A_CTRL, 32'h0000_0400);

        // Basic switch to team 2: 4 blank + 1 commit cycles
        writeReg("ctrl en", A_CTRL, 32'h0000_0401, 4'hf);
        modelEnable = 1'b1;
        writeReg("sel2", A_SEL, 32'd2, 4'hf);
        countBusy(n);
        checkOutput("busy window sel2", 128'(n), 128'd5);
        modelActive = 2;
        checkLaNext("la team2");
        for (int i = 0; i < 3; i++) begin
            driveTeam("la follows team2", 2, rand128());
        end
        driveTeam("la ignores team1", 1, rand128());
        readReg("status active2", A_STATUS, 32'h0000_0200);
        readReg("sel readback", A_SEL, 32'd2);
        writeReg("sel2 repeat", A_SEL, 32'd2, 4'hf);
        checkOutput("busy same sel", 128'(busyOut), 128'h0);

        // Restart: switch 1 -> 2, redirected to 3 in the second blank cycle
        writeReg("sel1", A_SEL, 32'd1, 4'hf);
        countBusy(n);
        modelActive = 1;
        checkLaNext("la team1");
        watchTeam2 = 1'b1;
        writeReg("sel2 interrupted", A_SEL, 32'd2, 4'hf);
        @(negedge clk);
        writeReg("sel3 restart", A_SEL, 32'd3, 4'hf);
        countBusy(n);
        checkOutput("busy window restart", 128'(n), 128'd5);
        modelActive = 3;
        checkLaNext("la team3");
        watchTeam2 = 1'b0;
        checkOutput("no team2 leak", 128'(sawTeam2), 128'h0);
        readReg("status active3", A_STATUS, 32'h0000_0300);

        // Out-of-range request and W1C
        writeReg("sel7", A_SEL, 32'd7, 4'hf);
        checkOutput("busy after bad sel", 128'(busyOut), 128'h0);
        readReg("status err", A_STATUS, 32'h0001_0300);
        readReg("sel unchanged", A_SEL, 32'd3);
        writeReg("w1c err", A_STATUS, 32'h0001_0000, 4'hf);
        readReg("status err clr", A_STATUS, 32'h0000_0300);

        // Byte-select CTRL write: blank_cycles=0, enable kept
        writeReg("ctrl byte1", A_CTRL, 32'h0000_0000, 4'b0010);
        readReg("ctrl blank0", A_CTRL, 32'h0000_0001);
        writeReg("sel1 fast", A_SEL, 32'd1, 4'hf);
        countBusy(n);
        checkOutput("busy window blank0", 128'(n), 128'd2);
        modelActive = 1;
        checkLaNext("la team1 fast");

        // Disabled output while sequencing continues
        writeReg("ctrl dis", A_CTRL, 32'h0000_0000, 4'b0001);
        modelEnable = 1'b0;
        checkLaNext("la disabled");
        writeReg("sel2 disabled", A_SEL, 32'd2, 4'hf);
        countBusy(n);
        checkOutput("busy window disabled", 128'(n), 128'd2);
        modelActive = 2;
        checkLaNext("la disabled team2");
        readReg("status disabled", A_STATUS, 32'h0000_0200);
        writeReg("ctrl reen", A_CTRL, 32'h0000_0401, 4'b0011);
        modelEnable = 1'b1;
        checkLaNext("la reenabled");

        // Reset in the middle of BLANK
        writeReg("sel3 prerst", A_SEL, 32'd3, 4'hf);
        checkOutput("busy before rst", 128'(busyOut), 128'h1);
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("async rst la", laOut, 128'h0);
        checkOutput("async rst busy", 128'(busyOut), 128'h0);
        checkOutput("async rst ack", 128'(wbIf.wbs_ack_o), 128'h0);
        modelActive = 0;
        modelEnable = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wbIf.wbs_ack_o || busyOut) n++;
        end
        checkOutput("idle after rst", 128'(n), 128'h0);
        readReg("status after rst", A_STATUS, 32'h0000_0000);
        readReg("ctrl after rst", A_CTRL, 32'h0000_0400);
        applyStimulus("miss +0x10", 1'b0, BASE + 32'h10, 32'h0, 4'hf, 1'b0);
        checkOutput("rdQ drained", 128'(rdQ.size()), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
